// File: rtl/ysyx_25040129_lsu.sv
// Load/store stage of the ysyx_25040129 RV32 pipeline: takes one instruction from EXU,
// performs at most one aligned bus access, and hands the result to WBU.
module ysyx_25040129_lsu #(
   parameter int REGS_DIG = 5,
   parameter int CSR_DIG  = 12
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                is_req_valid_from_exu,
   output logic                is_req_ready_to_exu,
   input  logic [REGS_DIG-1:0] rd_in_lsu,
   input  logic [31:0]         result_in_lsu,
   input  logic [31:0]         store_data_in_lsu,
   input  logic                mem_read_in_lsu,
   input  logic                mem_write_in_lsu,
   input  logic [2:0]          funct3_in_lsu,
   input  logic [CSR_DIG-1:0]  csr_addr_in_lsu,
   input  logic                csr_write_in_lsu,
   input  logic                reg_write_in_lsu,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [31:0]         mem_req_addr,
   output logic                mem_req_wen,
   output logic [31:0]         mem_req_wdata,
   output logic [3:0]          mem_req_wmask,
   input  logic                mem_resp_valid,
   input  logic [31:0]         mem_resp_rdata,
   input  logic                mem_resp_err,
   output logic                is_req_valid_to_wbu,
   input  logic                is_req_ready_from_wbu,
   output logic [REGS_DIG-1:0] rd_out_lsu,
   output logic [31:0]         result_out_lsu,
   output logic [CSR_DIG-1:0]  csr_addr_out_lsu,
   output logic                csr_write_out_lsu,
   output logic                reg_write_out_lsu,
   output logic                access_fault_out_lsu,
   output logic                is_data_forward_valid_from_lsu,
   output logic [31:0]         lsu_forward_data
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateT;

   stateT               state_q;
   logic [REGS_DIG-1:0] rd_q;
   logic [31:0]         addr_q;
   logic [31:0]         storeData_q;
   logic                isLoad_q;
   logic                isStore_q;
   logic [2:0]          funct3_q;
   logic [CSR_DIG-1:0]  csrAddr_q;
   logic                csrWrite_q;
   logic                regWrite_q;
   logic [31:0]         result_q;
   logic                fault_q;
   logic                wbRegWrite_q;

   logic                isMemIn;
   logic                misalignedIn;
   logic [3:0]          laneMask;
   logic [31:0]         laneData;
   logic [31:0]         shiftedWord;
   logic [31:0]         loadValue;

   // funct3[1:0] encodes the access size: 00 byte, 01 halfword, anything else a word.
   assign isMemIn      = mem_read_in_lsu | mem_write_in_lsu;
   assign misalignedIn = ((funct3_in_lsu[1:0] == 2'b01) & result_in_lsu[0]) |
                         (funct3_in_lsu[1] & (result_in_lsu[1:0] != 2'b00));

   always_comb begin
      laneMask = 4'b1111;
      laneData = storeData_q;
      case (funct3_q[1:0])
         2'b00: begin
            laneMask = 4'b0001 << addr_q[1:0];
            laneData = {4{storeData_q[7:0]}};
         end
         2'b01: begin
            laneMask = 4'b0011 << addr_q[1:0];
            laneData = {2{storeData_q[15:0]}};
         end
         default: begin
            laneMask = 4'b1111;
            laneData = storeData_q;
         end
      endcase
   end

   // Bring the addressed byte/halfword down to bit 0 before sign or zero extension.
   assign shiftedWord = mem_resp_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      loadValue = mem_resp_rdata;
      case (funct3_q)
         3'b000:  loadValue = {{24{shiftedWord[7]}}, shiftedWord[7:0]};
         3'b001:  loadValue = {{16{shiftedWord[15]}}, shiftedWord[15:0]};
         3'b100:  loadValue = {24'd0, shiftedWord[7:0]};
         3'b101:  loadValue = {16'd0, shiftedWord[15:0]};
         default: loadValue = mem_resp_rdata;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         rd_q         <= '0;
         addr_q       <= '0;
         storeData_q  <= '0;
         isLoad_q     <= 1'b0;
         isStore_q    <= 1'b0;
         funct3_q     <= '0;
         csrAddr_q    <= '0;
         csrWrite_q   <= 1'b0;
         regWrite_q   <= 1'b0;
         result_q     <= '0;
         fault_q      <= 1'b0;
         wbRegWrite_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (is_req_valid_from_exu) begin
                  rd_q        <= rd_in_lsu;
                  addr_q      <= result_in_lsu;
                  storeData_q <= store_data_in_lsu;
                  isLoad_q    <= mem_read_in_lsu;
                  isStore_q   <= mem_write_in_lsu & ~mem_read_in_lsu;
                  funct3_q    <= funct3_in_lsu;
                  csrAddr_q   <= csr_addr_in_lsu;
                  csrWrite_q  <= csr_write_in_lsu;
                  regWrite_q  <= reg_write_in_lsu;
                  if (!isMemIn) begin
                     result_q     <= result_in_lsu;
                     fault_q      <= 1'b0;
                     wbRegWrite_q <= reg_write_in_lsu;
                     state_q      <= DONE;
                  end else if (misalignedIn) begin
                     result_q     <= '0;
                     fault_q      <= 1'b1;
                     wbRegWrite_q <= 1'b0;
                     state_q      <= DONE;
                  end else begin
                     state_q <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  if (mem_resp_err) begin
                     result_q     <= '0;
                     fault_q      <= 1'b1;
                     wbRegWrite_q <= 1'b0;
                  end else begin
                     result_q     <= isLoad_q ? loadValue : 32'd0;
                     fault_q      <= 1'b0;
                     wbRegWrite_q <= regWrite_q;
                  end
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (is_req_ready_from_wbu) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign is_req_ready_to_exu = (state_q == IDLE);

   assign mem_req_valid = (state_q == REQ);
   assign mem_req_addr  = {addr_q[31:2], 2'b00};
   assign mem_req_wen   = isStore_q;
   assign mem_req_wdata = laneData;
   assign mem_req_wmask = isStore_q ? laneMask : 4'b0000;

   // Write enables and the fault flag only mean anything while the result is on offer.
   assign is_req_valid_to_wbu            = (state_q == DONE);
   assign rd_out_lsu                     = rd_q;
   assign result_out_lsu                 = result_q;
   assign csr_addr_out_lsu               = csrAddr_q;
   assign csr_write_out_lsu              = (state_q == DONE) & csrWrite_q;
   assign reg_write_out_lsu              = (state_q == DONE) & wbRegWrite_q;
   assign access_fault_out_lsu           = (state_q == DONE) & fault_q;
   assign is_data_forward_valid_from_lsu = reg_write_out_lsu;
   assign lsu_forward_data               = result_q;

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// Self-checking bench for ysyx_25040129_lsu: directed vector table, random operations
// against a byte-lane reference model, and reset-in-flight recovery.
module tb_ysyx_25040129_lsu;

   logic        clock;
   logic        reset;
   logic        validFromExu;
   logic        readyToExu;
   logic [4:0]  rdIn;
   logic [31:0] resultIn;
   logic [31:0] storeDataIn;
   logic        memReadIn;
   logic        memWriteIn;
   logic [2:0]  funct3In;
   logic [11:0] csrAddrIn;
   logic        csrWriteIn;
   logic        regWriteIn;
   logic        memReqValid;
   logic        memReqReady;
   logic [31:0] memReqAddr;
   logic        memReqWen;
   logic [31:0] memReqWdata;
   logic [3:0]  memReqWmask;
   logic        memRespValid;
   logic [31:0] memRespRdata;
   logic        memRespErr;
   logic        validToWbu;
   logic        readyFromWbu;
   logic [4:0]  rdOut;
   logic [31:0] resultOut;
   logic [11:0] csrAddrOut;
   logic        csrWriteOut;
   logic        regWriteOut;
   logic        faultOut;
   logic        fwdValid;
   logic [31:0] fwdData;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic        memRead;
      logic        memWrite;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic        err;
      logic        regw;
      logic        csrw;
      logic [4:0]  rd;
      logic [11:0] csr;
      int          readyDelay;
      int          wbuDelay;
      logic        spur;
      logic [31:0] expRes;
      logic        expFault;
      logic        expRegW;
      logic        expBus;
      logic [3:0]  expMask;
      logic [31:0] expWdata;
   } vecT;

   vecT tbl[12];

   ysyx_25040129_lsu #(.REGS_DIG(5), .CSR_DIG(12)) dut (
      .clock                          (clock),
      .reset                          (reset),
      .is_req_valid_from_exu          (validFromExu),
      .is_req_ready_to_exu            (readyToExu),
      .rd_in_lsu                      (rdIn),
      .result_in_lsu                  (resultIn),
      .store_data_in_lsu              (storeDataIn),
      .mem_read_in_lsu                (memReadIn),
      .mem_write_in_lsu               (memWriteIn),
      .funct3_in_lsu                  (funct3In),
      .csr_addr_in_lsu                (csrAddrIn),
      .csr_write_in_lsu               (csrWriteIn),
      .reg_write_in_lsu               (regWriteIn),
      .mem_req_valid                  (memReqValid),
      .mem_req_ready                  (memReqReady),
      .mem_req_addr                   (memReqAddr),
      .mem_req_wen                    (memReqWen),
      .mem_req_wdata                  (memReqWdata),
      .mem_req_wmask                  (memReqWmask),
      .mem_resp_valid                 (memRespValid),
      .mem_resp_rdata                 (memRespRdata),
      .mem_resp_err                   (memRespErr),
      .is_req_valid_to_wbu            (validToWbu),
      .is_req_ready_from_wbu          (readyFromWbu),
      .rd_out_lsu                     (rdOut),
      .result_out_lsu                 (resultOut),
      .csr_addr_out_lsu               (csrAddrOut),
      .csr_write_out_lsu              (csrWriteOut),
      .reg_write_out_lsu              (regWriteOut),
      .access_fault_out_lsu           (faultOut),
      .is_data_forward_valid_from_lsu (fwdValid),
      .lsu_forward_data               (fwdData)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: an access of `size` bytes at byte offset `off` in a little-endian word.
   function automatic vecT model(input vecT v);
      vecT     r = v;
      int      size;
      int      off;
      longint  val;
      size = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
      off  = int'(v.addr % 4);
      r.expBus   = 1'b0;
      r.expMask  = 4'b0000;
      r.expWdata = 32'd0;
      if (!(v.memRead || v.memWrite)) begin
         r.expRes = v.addr; r.expFault = 1'b0; r.expRegW = v.regw;
      end else if ((off % size) != 0) begin
         r.expRes = 32'd0; r.expFault = 1'b1; r.expRegW = 1'b0;
      end else begin
         r.expBus = 1'b1;
         if (v.memWrite && !v.memRead) begin
            r.expMask = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) r.expWdata[8*i +: 8] = v.sdata[8*(i % size) +: 8];
         end
         if (v.err) begin
            r.expRes = 32'd0; r.expFault = 1'b1; r.expRegW = 1'b0;
         end else if (v.memRead) begin
            val = (longint'(v.rdata) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
            if (size < 4 && !v.f3[2] && val >= (64'd1 << (8 * size - 1))) val = val - (64'd1 << (8 * size));
            r.expRes = val[31:0]; r.expFault = 1'b0; r.expRegW = v.regw;
         end else begin
            r.expRes = 32'd0; r.expFault = 1'b0; r.expRegW = v.regw;
         end
      end
      return r;
   endfunction

   function automatic vecT mkVec(input logic rdOp, input logic wrOp, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input logic err, input logic regw,
                                 input logic [4:0] rd, input int readyDelay, input int wbuDelay,
                                 input logic [31:0] expRes, input logic expFault, input logic expRegW);
      vecT v;
      v.memRead = rdOp; v.memWrite = wrOp; v.f3 = f3; v.addr = addr; v.sdata = sdata;
      v.rdata = rdata; v.err = err; v.regw = regw; v.rd = rd; v.csrw = 1'b0;
      v.csr = 12'h300 + 12'(rd); v.readyDelay = readyDelay; v.wbuDelay = wbuDelay; v.spur = 1'b1;
      v = model(v);
      v.expRes = expRes; v.expFault = expFault; v.expRegW = expRegW;
      return v;
   endfunction

   task automatic applyStimulus(input vecT v);
      int n;
      @(negedge clock);
      checkOutput("exu_ready_idle", 32'(readyToExu), 32'd1);
      rdIn = v.rd; resultIn = v.addr; storeDataIn = v.sdata; memReadIn = v.memRead;
      memWriteIn = v.memWrite; funct3In = v.f3; csrAddrIn = v.csr; csrWriteIn = v.csrw;
      regWriteIn = v.regw; validFromExu = 1'b1;
      @(negedge clock);
      validFromExu = 1'b0;
      checkOutput("exu_ready_busy", 32'(readyToExu), 32'd0);
      if (v.expBus) begin
         checkOutput("req_valid", 32'(memReqValid), 32'd1);
         if (!memReqValid) return;
         for (int c = 0; c <= v.readyDelay; c++) begin
            checkOutput("req_addr", memReqAddr, v.addr & 32'hFFFF_FFFC);
            checkOutput("req_wen", 32'(memReqWen), 32'(v.memWrite & ~v.memRead));
            if (v.memWrite && !v.memRead) begin
               checkOutput("req_wmask", 32'(memReqWmask), 32'(v.expMask));
               checkOutput("req_wdata", memReqWdata, v.expWdata);
            end
            if (c < v.readyDelay) begin
               memRespValid = v.spur; memRespRdata = $urandom;
               @(negedge clock);
               checkOutput("req_valid_held", 32'(memReqValid), 32'd1);
            end
         end
         memRespValid = 1'b0; memReqReady = 1'b1;
         @(negedge clock);
         memReqReady = 1'b0;
         checkOutput("req_dropped", 32'(memReqValid), 32'd0);
         checkOutput("wbu_early", 32'(validToWbu), 32'd0);
         memRespValid = 1'b1; memRespRdata = v.rdata; memRespErr = v.err;
         @(negedge clock);
         memRespValid = 1'b0; memRespErr = 1'b0;
      end else begin
         checkOutput("no_req", 32'(memReqValid), 32'd0);
      end
      n = 0;
      while (!validToWbu && n < 8) begin
         @(negedge clock);
         n++;
      end
      checkOutput("wbu_valid", 32'(validToWbu), 32'd1);
      if (!validToWbu) return;
      for (int c = 0; c <= v.wbuDelay; c++) begin
         checkOutput("result", resultOut, v.expRes);
         checkOutput("fault", 32'(faultOut), 32'(v.expFault));
         checkOutput("reg_write", 32'(regWriteOut), 32'(v.expRegW));
         checkOutput("rd_out", 32'(rdOut), 32'(v.rd));
         checkOutput("csr_addr", 32'(csrAddrOut), 32'(v.csr));
         checkOutput("csr_write", 32'(csrWriteOut), 32'(v.csrw));
         checkOutput("fwd_valid", 32'(fwdValid), 32'(v.expRegW));
         checkOutput("fwd_data", fwdData, v.expRes);
         checkOutput("exu_ready_done", 32'(readyToExu), 32'd0);
         if (c < v.wbuDelay) begin
            @(negedge clock);
            checkOutput("wbu_valid_held", 32'(validToWbu), 32'd1);
         end
      end
      readyFromWbu = 1'b1;
      @(negedge clock);
      readyFromWbu = 1'b0;
      checkOutput("wbu_released", 32'(validToWbu), 32'd0);
      checkOutput("exu_ready_after", 32'(readyToExu), 32'd1);
      checkOutput("reg_write_idle", 32'(regWriteOut), 32'd0);
   endtask

   initial begin
      vecT v;
      int  kind;
      reset = 1'b0; validFromExu = 1'b0; rdIn = '0; resultIn = '0; storeDataIn = '0;
      memReadIn = 1'b0; memWriteIn = 1'b0; funct3In = '0; csrAddrIn = '0; csrWriteIn = 1'b0;
      regWriteIn = 1'b0; memReqReady = 1'b0; memRespValid = 1'b0; memRespRdata = '0;
      memRespErr = 1'b0; readyFromWbu = 1'b0;

      tbl[0]  = mkVec(0, 0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 0, 1, 5, 0, 0, 32'h1234_5678, 0, 1);
      tbl[1]  = mkVec(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 0, 1, 6, 0, 0, 32'hFFFF_FF80, 0, 1);
      tbl[2]  = mkVec(1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 0, 1, 7, 0, 0, 32'h0000_0080, 0, 1);
      tbl[3]  = mkVec(0, 1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 0, 0, 0, 3, 0, 32'h0, 0, 0);
      tbl[3].expMask = 4'b1100; tbl[3].expWdata = 32'hABCD_ABCD;
      tbl[4]  = mkVec(1, 0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 0, 1, 8, 0, 0, 32'h0, 1, 0);
      tbl[5]  = mkVec(1, 0, 3'b010, 32'h8000_0008, 32'h0, 32'h5555_AAAA, 1, 1, 9, 1, 0, 32'h0, 1, 0);
      tbl[6]  = mkVec(0, 0, 3'b000, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 1, 10, 0, 4, 32'hCAFE_F00D, 0, 1);
      tbl[7]  = mkVec(1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 1, 11, 0, 0, 32'hFFFF_8001, 0, 1);
      tbl[8]  = mkVec(1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 1, 12, 0, 0, 32'h0000_8001, 0, 1);
      tbl[9]  = mkVec(0, 1, 3'b000, 32'h8000_0001, 32'h0000_00EF, 32'h0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
      tbl[9].expMask = 4'b0010; tbl[9].expWdata = 32'hEFEF_EFEF;
      tbl[10] = mkVec(1, 1, 3'b010, 32'h8000_0004, 32'h1111_2222, 32'hDEAD_BEEF, 0, 1, 13, 0, 1, 32'hDEAD_BEEF, 0, 1);
      tbl[11] = mkVec(1, 0, 3'b001, 32'h8000_0003, 32'h0, 32'h0, 0, 1, 14, 0, 0, 32'h0, 1, 0);
      tbl[6].csrw = 1'b1;

      repeat (2) @(negedge clock);
      checkOutput("rst_exu_ready", 32'(readyToExu), 32'd1);
      checkOutput("rst_wbu_valid", 32'(validToWbu), 32'd0);
      checkOutput("rst_req_valid", 32'(memReqValid), 32'd0);
      checkOutput("rst_reg_write", 32'(regWriteOut), 32'd0);
      checkOutput("rst_fault", 32'(faultOut), 32'd0);
      checkOutput("rst_result", resultOut, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("post_rst_exu_ready", 32'(readyToExu), 32'd1);
      checkOutput("post_rst_wbu_valid", 32'(validToWbu), 32'd0);

      for (int i = 0; i < 12; i++) applyStimulus(tbl[i]);

      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 3);
         v.memRead  = (kind == 1) || (kind == 3);
         v.memWrite = (kind == 2) || (kind == 3);
         v.f3       = (kind == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         v.addr     = $urandom;
         if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
         v.sdata = $urandom; v.rdata = $urandom; v.err = ($urandom_range(0, 7) == 0);
         v.regw = 1'($urandom); v.csrw = 1'($urandom); v.rd = 5'($urandom); v.csr = 12'($urandom);
         v.readyDelay = $urandom_range(0, 2); v.wbuDelay = $urandom_range(0, 2);
         v.spur = 1'($urandom);
         applyStimulus(model(v));
      end

      // Reset while a load is waiting for its response must abandon it cleanly.
      @(negedge clock);
      rdIn = 5'd3; resultIn = 32'h8000_0010; memReadIn = 1'b1; memWriteIn = 1'b0;
      funct3In = 3'b010; regWriteIn = 1'b1; csrWriteIn = 1'b0; validFromExu = 1'b1;
      @(negedge clock);
      validFromExu = 1'b0;
      checkOutput("rstseq_req", 32'(memReqValid), 32'd1);
      memReqReady = 1'b1;
      @(negedge clock);
      memReqReady = 1'b0;
      checkOutput("rstseq_wait", 32'(memReqValid | readyToExu | validToWbu), 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("rstseq_exu_ready", 32'(readyToExu), 32'd1);
      checkOutput("rstseq_wbu_valid", 32'(validToWbu), 32'd0);
      checkOutput("rstseq_req_valid", 32'(memReqValid), 32'd0);
      checkOutput("rstseq_reg_write", 32'(regWriteOut), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("rstseq_idle", 32'(readyToExu), 32'd1);
      applyStimulus(tbl[0]);
      applyStimulus(tbl[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/ysyx_25040129_lsu.md
Name: ysyx_25040129_lsu

Overview:
- Load/store stage of the ysyx_25040129 pipelined RV32 core, between EXU (upstream) and WBU (downstream).
- Accepts one instruction at a time from EXU and passes non-memory results through.
- Runs a single-outstanding load/store on a simple request/response data bus.
- Presents the final result, rd, CSR and write-enable fields to WBU with a valid/ready handshake and drives a forwarding tap.

Parameters:
REGS_DIG, 5, width of register index
CSR_DIG, 12, width of CSR address

Ports:
clock  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
is_req_valid_from_exu  in  1  EXU has an instruction
is_req_ready_to_exu  out  1  LSU can accept
rd_in_lsu  in  REGS_DIG  destination register
result_in_lsu  in  32  ALU result; effective address for loads/stores
store_data_in_lsu  in  32  rs2 value for stores
mem_read_in_lsu  in  1  load
mem_write_in_lsu  in  1  store
funct3_in_lsu  in  3  RV32 size/sign code
csr_addr_in_lsu  in  CSR_DIG  CSR address
csr_write_in_lsu  in  1  CSR write enable
reg_write_in_lsu  in  1  GPR write enable
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_addr  out  32  word-aligned address (addr & ~3)
mem_req_wen  out  1  1 = store
mem_req_wdata  out  32  lane-shifted store data
mem_req_wmask  out  4  byte strobes
mem_resp_valid  in  1  response valid, one cycle
mem_resp_rdata  in  32  load word
mem_resp_err  in  1  bus error
is_req_valid_to_wbu  out  1  result valid to WBU
is_req_ready_from_wbu  in  1  WBU accepts
rd_out_lsu  out  REGS_DIG  latched rd
result_out_lsu  out  32  final result
csr_addr_out_lsu  out  CSR_DIG  latched CSR address
csr_write_out_lsu  out  1  latched CSR write enable
reg_write_out_lsu  out  1  GPR write enable (0 on fault)
access_fault_out_lsu  out  1  misaligned or bus error, valid with result
is_data_forward_valid_from_lsu  out  1  forward tap valid
lsu_forward_data  out  32  equals result_out_lsu

Behaviour:
- Reset: async assert to state IDLE. All valid outputs, mem_req_valid, reg_write_out_lsu, csr_write_out_lsu and access_fault_out_lsu are 0. Data registers are 0.
- FSM states: IDLE, REQ, WAIT, DONE. is_req_ready_to_exu = (state == IDLE).
- IDLE, on valid from EXU: latch all inputs.
  - Neither mem_read nor mem_write: result = result_in -> DONE. Result is at WBU on the next cycle.
  - Memory op, aligned: -> REQ.
  - Memory op, misaligned (halfword addr[0]=1; word addr[1:0]!=0): no bus access; result=0, fault=1, reg_write=0 -> DONE.
  - mem_read and mem_write together: treat as a load.
- REQ: mem_req_valid=1 with stable addr/wen/wdata/wmask until mem_req_ready. The cycle with valid&ready moves to WAIT.
- WAIT: on mem_resp_valid, capture the response -> DONE.
  - Load: extract by addr[1:0]. funct3 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext. Other codes behave as LW.
  - Store: result=0; reg_write as latched (normally 0).
  - mem_resp_err=1: result=0, fault=1, reg_write=0.
- Store lanes:
  - SB: wmask = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: wmask = 0011 << addr[1:0]; wdata = halfword replicated x2.
  - SW: wmask = 1111.
- DONE: is_req_valid_to_wbu=1 and all outputs held until is_req_ready_from_wbu, then -> IDLE. No new accept occurs in the same cycle.
- Throughput: 1 instruction per 2 cycles for non-memory ops; memory ops take at least 4 cycles.
- Forwarding: is_data_forward_valid_from_lsu = (state == DONE) & reg_write_out_lsu.
- reg_write_out_lsu and csr_write_out_lsu are only ever 1 in DONE.
- Reset mid-operation (any state): immediate return to IDLE. The bus shares the same reset, so no stale response arrives afterward.
- mem_resp_valid outside WAIT is ignored.

Test Plan:
- Reset low, then high -> ready_to_exu=1, valid_to_wbu=0, mem_req_valid=0, reg_write_out=0.
- Non-mem op: result=0x1234_5678, rd=5, reg_write=1, WBU ready=1 -> next cycle valid_to_wbu=1, result_out=0x12345678, rd_out=5, forward valid=1; the cycle after, ready_to_exu=1.
- LB at addr 0x8000_0003, resp_rdata=0x80FF_FFFF -> mem_req_addr=0x8000_0000, wen=0; result_out=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- SH at addr 0x8000_0002, store_data=0x0000_ABCD, mem_req_ready held low 3 cycles -> mem_req_valid stays 1 with stable fields; wmask=1100, wdata=0xABCD_ABCD; reg_write_out=0.
- LW at addr 0x8000_0001 -> no mem_req_valid; DONE with fault=1, result=0, reg_write_out=0. Separately, LW with mem_resp_err=1 -> same outputs.
- DONE with WBU ready held low 4 cycles -> all outputs stable, ready_to_exu=0. Then assert reset for one cycle while in WAIT -> IDLE, all valids 0.
